// File: rtl/cfg_pkg.sv
// Shared constants and types for the PWM configuration register arbiter.
package cfg_pkg;

    // Register addresses of the five PWM configuration registers.
    localparam int unsigned ADDR_OUT_LO  = 32'h00;
    localparam int unsigned ADDR_OUT_HI  = 32'h01;
    localparam int unsigned ADDR_PWM_LO  = 32'h02;
    localparam int unsigned ADDR_PWM_HI  = 32'h03;
    localparam int unsigned ADDR_DUTY    = 32'h04;

    // Value every configuration register takes on reset.
    localparam int unsigned REG_RST_VAL  = 32'h00;

    // Bus lock state.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after the last
// granted index and the first eligible (requesting and unmasked) index wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int LG_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [LG_W-1:0]    last_grant,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] eligible;
    assign eligible = req & mask;

    // Walk the requesters in priority order and pick the first eligible one.
    always_comb begin
        logic            found;
        logic [LG_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = LG_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// PWM configuration register bank with round-robin shared write access and
// a lockable bus (with idle timeout) for atomic multi-register updates.
module cfg_reg_arbiter
    import cfg_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 8,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         en_reg_out_7_0,
    output logic [DATA_W-1:0]         en_reg_out_15_8,
    output logic [DATA_W-1:0]         en_reg_pwm_7_0,
    output logic [DATA_W-1:0]         en_reg_pwm_15_8,
    output logic [DATA_W-1:0]         pwm_duty_cycle,
    output logic                      addr_err,
    output logic                      lock_timeout,
    output logic [7:0]                err_count
);

    localparam int LG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    state_t             state;
    logic [LG_W-1:0]    last_grant;
    logic [LG_W-1:0]    owner;
    logic [CNT_W-1:0]   lock_cnt;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic [LG_W-1:0]    gidx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_lock;

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // While locked only the owner may be granted.
    assign mask = (state == ST_IDLE) ? {NUM_REQ{1'b1}} : (NUM_REQ'(1) << owner);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .mask       (mask),
        .grant      (grant)
    );

    assign req_ready = rst_n ? grant : '0;
    assign xfer      = |(req_valid & req_ready);

    // Select the index, address, data and lock flag of the granted requester.
    always_comb begin
        gidx     = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_lock = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                gidx     = LG_W'(k);
                sel_addr = req_addr[k*ADDR_W +: ADDR_W];
                sel_data = req_data[k*DATA_W +: DATA_W];
                sel_lock = req_lock[k];
            end
        end
    end

    // Lock FSM: grant history, lock ownership and idle timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            owner        <= '0;
            last_grant   <= LG_W'(NUM_REQ - 1);
            lock_cnt     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            lock_timeout <= 1'b0;
            if (xfer)
                last_grant <= gidx;
            case (state)
                ST_IDLE: begin
                    if (xfer && sel_lock) begin
                        state    <= ST_LOCKED;
                        owner    <= gidx;
                        lock_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    // An owner transfer always beats a coincident timeout.
                    if (xfer) begin
                        if (!sel_lock)
                            state <= ST_IDLE;
                        lock_cnt <= '0;
                    end else if (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state        <= ST_IDLE;
                        lock_timeout <= 1'b1;
                        last_grant   <= owner;
                        lock_cnt     <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register bank writes and unmapped-address error reporting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= DATA_W'(REG_RST_VAL);
            en_reg_out_15_8 <= DATA_W'(REG_RST_VAL);
            en_reg_pwm_7_0  <= DATA_W'(REG_RST_VAL);
            en_reg_pwm_15_8 <= DATA_W'(REG_RST_VAL);
            pwm_duty_cycle  <= DATA_W'(REG_RST_VAL);
            addr_err        <= 1'b0;
            err_count       <= 8'h00;
        end else begin
            addr_err <= 1'b0;
            if (xfer) begin
                if (sel_addr == ADDR_W'(ADDR_OUT_LO))
                    en_reg_out_7_0 <= sel_data;
                else if (sel_addr == ADDR_W'(ADDR_OUT_HI))
                    en_reg_out_15_8 <= sel_data;
                else if (sel_addr == ADDR_W'(ADDR_PWM_LO))
                    en_reg_pwm_7_0 <= sel_data;
                else if (sel_addr == ADDR_W'(ADDR_PWM_HI))
                    en_reg_pwm_15_8 <= sel_data;
                else if (sel_addr == ADDR_W'(ADDR_DUTY))
                    pwm_duty_cycle <= sel_data;
                else begin
                    addr_err  <= 1'b1;
                    err_count <= sat_inc(err_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Directed self-checking bench for cfg_reg_arbiter (2 requesters).
module tb_cfg_reg_arbiter;

    localparam int NUM_REQ      = 2;
    localparam int ADDR_W       = 7;
    localparam int DATA_W       = 8;
    localparam int LOCK_TIMEOUT = 64;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [7:0]                en_reg_out_7_0, en_reg_out_15_8;
    logic [7:0]                en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic                      addr_err, lock_timeout;
    logic [7:0]                err_count;

    int checks = 0;
    int errors = 0;

    cfg_reg_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle),
        .addr_err(addr_err), .lock_timeout(lock_timeout), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  lock;
        logic [6:0]  a0;
        logic [7:0]  d0;
        logic [6:0]  a1;
        logic [7:0]  d1;
        logic [1:0]  exp_ready;
        logic [39:0] exp_regs;   // {out_lo, out_hi, pwm_lo, pwm_hi, duty}
        logic        exp_aerr;
        logic [7:0]  exp_ecnt;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [39:0] regs();
        return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l,
                         input logic [6:0] a0, input logic [7:0] d0,
                         input logic [6:0] a1, input logic [7:0] d1);
        req_valid = v;
        req_lock  = l;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad_ready;
        int bad_pulse;
        int bad_aerr;
        logic [39:0] snap;

        vecs[0] = '{2'b01, 2'b00, 7'h04, 8'h80, 7'h00, 8'h00, 2'b01, 40'h00_00_00_00_80, 1'b0, 8'h00};
        vecs[1] = '{2'b11, 2'b00, 7'h00, 8'h11, 7'h00, 8'h22, 2'b10, 40'h22_00_00_00_80, 1'b0, 8'h00};
        vecs[2] = '{2'b11, 2'b00, 7'h00, 8'h11, 7'h00, 8'h22, 2'b01, 40'h11_00_00_00_80, 1'b0, 8'h00};
        vecs[3] = '{2'b11, 2'b00, 7'h00, 8'h11, 7'h00, 8'h22, 2'b10, 40'h22_00_00_00_80, 1'b0, 8'h00};
        vecs[4] = '{2'b11, 2'b00, 7'h00, 8'h11, 7'h00, 8'h22, 2'b01, 40'h11_00_00_00_80, 1'b0, 8'h00};
        vecs[5] = '{2'b10, 2'b00, 7'h00, 8'h00, 7'h01, 8'hA5, 2'b10, 40'h11_A5_00_00_80, 1'b0, 8'h00};
        vecs[6] = '{2'b00, 2'b00, 7'h00, 8'hDE, 7'h01, 8'hAD, 2'b00, 40'h11_A5_00_00_80, 1'b0, 8'h00};
        vecs[7] = '{2'b11, 2'b00, 7'h03, 8'h3C, 7'h02, 8'hC3, 2'b01, 40'h11_A5_00_3C_80, 1'b0, 8'h00};
        vecs[8] = '{2'b11, 2'b00, 7'h03, 8'h3C, 7'h02, 8'hC3, 2'b10, 40'h11_A5_C3_3C_80, 1'b0, 8'h00};
        vecs[9] = '{2'b01, 2'b00, 7'h05, 8'hFF, 7'h00, 8'h00, 2'b01, 40'h11_A5_C3_3C_80, 1'b1, 8'h01};

        // Reset state
        rst_n = 1'b0;
        drive(2'b11, 2'b00, 7'h00, 8'hAA, 7'h00, 8'hBB);
        tick();
        tick();
        check("reset_ready", req_ready, 2'b00);
        check("reset_regs", regs(), 40'h0);
        check("reset_flags", {addr_err, lock_timeout, err_count}, 10'h0);
        drive(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 8'h00);
        rst_n = 1'b1;
        tick();

        // Table-driven writes and round-robin alternation
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].lock, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
            #1;
            check($sformatf("vec%0d_ready", i), req_ready, vecs[i].exp_ready);
            tick();
            check($sformatf("vec%0d_regs", i), regs(), vecs[i].exp_regs);
            check($sformatf("vec%0d_aerr", i), addr_err, vecs[i].exp_aerr);
            check($sformatf("vec%0d_ecnt", i), err_count, vecs[i].exp_ecnt);
        end
        drive(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 8'h00);
        tick();
        check("aerr_one_cycle", addr_err, 1'b0);

        // Lock by requester 1 while requester 0 keeps requesting
        drive(2'b11, 2'b10, 7'h00, 8'h77, 7'h02, 8'h5A);
        #1;
        check("lock_first_ready", req_ready, 2'b10);
        tick();
        check("lock_first_write", en_reg_pwm_7_0, 8'h5A);
        drive(2'b11, 2'b10, 7'h00, 8'h77, 7'h03, 8'h6B);
        #1;
        check("lock_second_ready", req_ready, 2'b10);
        tick();
        check("lock_second_write", en_reg_pwm_15_8, 8'h6B);
        drive(2'b11, 2'b00, 7'h00, 8'h77, 7'h04, 8'h7C);
        #1;
        check("lock_last_ready", req_ready, 2'b10);
        tick();
        check("lock_last_write", {en_reg_out_7_0, pwm_duty_cycle}, 16'h11_7C);
        drive(2'b11, 2'b00, 7'h00, 8'h77, 7'h04, 8'h01);
        #1;
        check("unlock_req0_ready", req_ready, 2'b01);
        tick();
        check("unlock_req0_write", {en_reg_out_7_0, pwm_duty_cycle}, 16'h77_7C);

        // Lock by requester 0, then idle until the lock times out
        drive(2'b01, 2'b01, 7'h00, 8'h99, 7'h01, 8'hEE);
        #1;
        check("to_lock_ready", req_ready, 2'b01);
        tick();
        check("to_lock_write", en_reg_out_7_0, 8'h99);
        drive(2'b10, 2'b00, 7'h00, 8'h99, 7'h01, 8'hEE);
        bad_ready = 0;
        bad_pulse = 0;
        for (int i = 1; i <= LOCK_TIMEOUT; i++) begin
            #1;
            if (req_ready !== 2'b00) bad_ready++;
            tick();
            if (i < LOCK_TIMEOUT && lock_timeout !== 1'b0) bad_pulse++;
        end
        check("to_stall_ready", bad_ready, 0);
        check("to_early_pulse", bad_pulse, 0);
        check("to_pulse", lock_timeout, 1'b1);
        check("to_req1_ready", req_ready, 2'b10);
        tick();
        check("to_pulse_end", lock_timeout, 1'b0);
        check("to_req1_write", en_reg_out_15_8, 8'hEE);

        // Unmapped writes until the error counter saturates
        snap = regs();
        bad_aerr = 0;
        for (int i = 0; i <= 300; i++) begin
            drive(2'b01, 2'b00, (i % 2 == 0) ? 7'h05 : 7'h7F, 8'h5F, 7'h00, 8'h00);
            tick();
            if (addr_err !== 1'b1) bad_aerr++;
        end
        check("sat_aerr_each", bad_aerr, 0);
        check("sat_ecnt", err_count, 8'hFF);
        check("sat_regs", regs(), snap);
        drive(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 8'h00);
        tick();
        check("sat_hold", {addr_err, err_count}, 9'h0FF);

        // Reset while locked with a pending write
        drive(2'b01, 2'b01, 7'h00, 8'h12, 7'h00, 8'h00);
        tick();
        check("rl_lock_write", en_reg_out_7_0, 8'h12);
        drive(2'b11, 2'b01, 7'h01, 8'h34, 7'h02, 8'h56);
        #1;
        check("rl_owner_ready", req_ready, 2'b01);
        rst_n = 1'b0;
        #1;
        check("rl_ready_in_reset", req_ready, 2'b00);
        tick();
        check("rl_regs", regs(), 40'h0);
        check("rl_ecnt", err_count, 8'h00);
        rst_n = 1'b1;
        drive(2'b10, 2'b00, 7'h01, 8'h34, 7'h02, 8'h56);
        #1;
        check("rl_idle_req1", req_ready, 2'b10);
        drive(2'b11, 2'b00, 7'h01, 8'h34, 7'h02, 8'h56);
        #1;
        check("rl_first_req0", req_ready, 2'b01);
        tick();
        check("rl_post_write", regs(), 40'h00_34_00_00_00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
